// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle for decode_stage.
// master: fetch/execute side; slave: the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [PC_WIDTH-1:0]  in_pc;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_WIDTH-1:0]  pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [XLEN-1:0]      imm;
    logic [2:0]           imm_src;
    logic [1:0]           result_src;
    logic [4:0]           ALU_control;
    logic                 ALU_src;
    logic                 ALU_a_pc;
    logic                 jump;
    logic                 jalr;
    logic                 branch;
    logic                 register_write;
    logic                 memory_write;
    logic [2:0]           funct3;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] illegal_count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, pc, rs1, rs2, rd, imm, imm_src, result_src,
               ALU_control, ALU_src, ALU_a_pc, jump, jalr, branch,
               register_write, memory_write, funct3, illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, pc, rs1, rs2, rd, imm, imm_src, result_src,
               ALU_control, ALU_src, ALU_a_pc, jump, jalr, branch,
               register_write, memory_write, funct3, illegal, illegal_count
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with ID/EX register, backpressure, flush and illegal counting.
// Define RV32M_EN to decode the M extension (funct7 0000001 on OP) instead of flagging it illegal.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave d
);
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SLT    = 5'b00101,
        ALU_SLTU   = 5'b00110,
        ALU_SLL    = 5'b00111,
        ALU_SRL    = 5'b01000,
        ALU_SRA    = 5'b01001,
        ALU_PASS_B = 5'b01010
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_t;

    // alt selects sub (funct3 000) or sra (funct3 101); callers decide when it applies
    function automatic logic [4:0] alu_fn(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

    logic [31:0]     ins;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, dec_imm;
    imm_sel_t        dec_imm_src;
    logic [1:0]      dec_result_src;
    logic [4:0]      dec_alu;
    logic            dec_alu_src, dec_a_pc, dec_jump, dec_jalr, dec_branch;
    logic            dec_reg_write, dec_mem_write, dec_rs2_zero, legal;
    logic            accept;

    assign ins    = d.in_instr;
    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];

    assign imm_i = XLEN'($signed(ins[31:20]));
    assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));

    always_comb begin
        dec_imm_src    = IMM_I;
        dec_result_src = 2'b00;
        dec_alu        = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_a_pc       = 1'b0;
        dec_jump       = 1'b0;
        dec_jalr       = 1'b0;
        dec_branch     = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_rs2_zero   = 1'b0;
        legal          = 1'b1;
        case (opcode)
            OP_LOAD: begin
                dec_result_src = 2'b01;
                dec_alu_src    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_rs2_zero   = 1'b1;
            end
            OP_STORE: begin
                dec_imm_src   = IMM_S;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_REG: begin
                dec_reg_write = 1'b1;
                if (f7 == 7'b0000000 || f7 == 7'b0100000)
                    dec_alu = alu_fn(f3, f7[5]);
`ifdef RV32M_EN
                else if (f7 == 7'b0000001)
                    dec_alu = {2'b10, f3};
`endif
                else
                    legal = 1'b0;
            end
            OP_IMM: begin
                dec_alu       = alu_fn(f3, (f3 == 3'b101) && f7[5]);
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_rs2_zero  = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm_src = IMM_B;
                dec_alu     = ALU_SUB;
                dec_branch  = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec_imm_src    = (opcode == OP_JAL) ? IMM_J : IMM_I;
                dec_result_src = 2'b10;
                dec_alu_src    = 1'b1;
                dec_jump       = 1'b1;
                dec_jalr       = (opcode == OP_JALR);
                dec_reg_write  = 1'b1;
                dec_rs2_zero   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm_src   = IMM_U;
                dec_alu       = (opcode == OP_LUI) ? ALU_PASS_B : ALU_ADD;
                dec_a_pc      = (opcode == OP_AUIPC);
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_rs2_zero  = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: dec_rs2_zero = 1'b1;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_result_src = 2'b00;
            dec_alu        = ALU_ADD;
            dec_alu_src    = 1'b0;
            dec_a_pc       = 1'b0;
            dec_jump       = 1'b0;
            dec_jalr       = 1'b0;
            dec_branch     = 1'b0;
            dec_reg_write  = 1'b0;
            dec_mem_write  = 1'b0;
        end
    end

    always_comb begin
        case (dec_imm_src)
            IMM_S:   dec_imm = imm_s;
            IMM_B:   dec_imm = imm_b;
            IMM_J:   dec_imm = imm_j;
            IMM_U:   dec_imm = imm_u;
            default: dec_imm = imm_i;
        endcase
    end

    assign d.in_ready = !d.out_valid || d.out_ready;
    assign accept     = d.in_valid && d.in_ready;

    // flush outranks a same-cycle transfer: nothing loads and nothing is counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d.out_valid      <= 1'b0;
            d.pc             <= '0;
            d.rs1            <= '0;
            d.rs2            <= '0;
            d.rd             <= '0;
            d.imm            <= '0;
            d.imm_src        <= '0;
            d.result_src     <= '0;
            d.ALU_control    <= '0;
            d.ALU_src        <= 1'b0;
            d.ALU_a_pc       <= 1'b0;
            d.jump           <= 1'b0;
            d.jalr           <= 1'b0;
            d.branch         <= 1'b0;
            d.register_write <= 1'b0;
            d.memory_write   <= 1'b0;
            d.funct3         <= '0;
            d.illegal        <= 1'b0;
            d.illegal_count  <= '0;
        end else if (d.flush) begin
            d.out_valid <= 1'b0;
        end else if (accept) begin
            d.out_valid      <= 1'b1;
            d.pc             <= d.in_pc;
            d.rs1            <= ins[19:15];
            d.rs2            <= dec_rs2_zero ? 5'd0 : ins[24:20];
            d.rd             <= ins[11:7];
            d.imm            <= dec_imm;
            d.imm_src        <= dec_imm_src;
            d.result_src     <= dec_result_src;
            d.ALU_control    <= dec_alu;
            d.ALU_src        <= dec_alu_src;
            d.ALU_a_pc       <= dec_a_pc;
            d.jump           <= dec_jump;
            d.jalr           <= dec_jalr;
            d.branch         <= dec_branch;
            d.register_write <= dec_reg_write;
            d.memory_write   <= dec_mem_write;
            d.funct3         <= f3;
            d.illegal        <= !legal;
            if (!legal && d.illegal_count != '1)
                d.illegal_count <= d.illegal_count + 1'b1;
        end else if (d.out_ready) begin
            d.out_valid <= 1'b0;
        end
    end
endmodule
